xpar_mbox: RTL and testbench
============================

# xpar_mbox

Responder for the picoVersat external parallel interface (`par_addr`, `par_we`, `par_out`, `par_in`). It gives the processor a small register map backed by two FIFOs:
- an RX FIFO, host to CPU;
- a TX FIFO, CPU to host.

It sits outside `xtop` on the external parallel bus. A ready/valid stream port faces the board-level host or peripheral logic.

## Interface
- `DATA_W`, 32, width of parallel data and FIFO words
- `PAR_ADDR_W`, 8, width of `par_addr` (equals `ADDR_W-1` of the core)
- `FIFO_LOG2`, 3, log2 of each FIFO depth (default depth 8)

- `clk` in 1: system clock; one clock domain, all state updates on rising edge
- `rst` in 1: reset, synchronous, active-high
- `par_addr` in `PAR_ADDR_W`: register address from core; only bits [1:0] decoded, upper bits must be 0 or the access is ignored/reads 0
- `par_we` in 1: write strobe from core, valid for one cycle
- `par_out` in `DATA_W`: write data from core
- `par_in` out `DATA_W`: read data to core, combinational from `par_addr` and registered state
- `rx_data` in `DATA_W`: host word into RX FIFO
- `rx_valid` in 1: host word valid
- `rx_ready` out 1: RX FIFO accepts; equals not rx_full, forced 0 while `rst`
- `tx_data` out `DATA_W`: TX FIFO head word
- `tx_valid` out 1: TX FIFO non-empty
- `tx_ready` in 1: host consumes head

## Operation
Register map, selected by `par_addr`[1:0]:
- 0 RX_DATA, read: RX head word; 0 when RX empty; a read has no side effect.
- 1 STATUS, read-only:
  - [0] rx_empty
  - [1] rx_full
  - [2] tx_empty
  - [3] tx_full
  - [7:4] rx_count
  - [11:8] tx_count
  - [12] ovf sticky
  - others 0
- 2 TX_DATA, write: pushes `par_out` into the TX FIFO. If the FIFO is full the word is dropped and ovf is set. Reads return 0.
- 3 CTRL, write only (reads 0):
  - bit0: pop the RX head (no-op if empty)
  - bit1: clear ovf
  - bit2: flush both FIFOs
  - Multiple bits may be set in one write.

Writes to RX_DATA and STATUS are ignored.

FIFO behaviour:
- Each FIFO is a circular buffer with read and write pointers of `FIFO_LOG2` bits plus a count of `FIFO_LOG2`+1 bits.
- Pointers wrap modulo depth.
- Counts saturate logically: full means count == depth.
- Host RX push occurs when `rx_valid && rx_ready`. Host TX pop occurs when `tx_valid && tx_ready`.
- Simultaneous push and pop on the same FIFO: both occur and the count is unchanged. The full and empty decisions use the pre-edge state. A push into a full FIFO is refused even if a pop happens in the same cycle.
- Flush has priority over every push and pop in the same cycle. After a flush, pointers and counts are 0. ovf is unaffected unless bit1 is also set.
- An ovf set and an ovf clear in the same cycle cannot both occur, because TX_DATA and CTRL are different addresses.

## Timing
- Reset clears pointers, counts and ovf. Output values after reset:
  - `tx_valid`=0
  - `tx_data`=0
  - `par_in`=0 for RX_DATA, 0x5 for STATUS
  - `rx_ready`=1 from the first cycle after `rst` falls
- Reset mid-transfer discards all FIFO contents with no partial word.
- Read latency is zero: `par_in` is valid in the same cycle as `par_addr`.
- A write takes effect at the next rising edge. STATUS, `tx_valid` and `rx_ready` reflect it in the following cycle.
- There is no bypass. A word pushed into an empty TX FIFO appears on `tx_valid` one cycle later. An RX word accepted at edge N is readable at RX_DATA after edge N.
- TX host throughput is one word per cycle. RX throughput is one word per cycle from the host and one per CTRL pop from the CPU.

## Configuration
- `PAR_MBOX_IRQ_EN` defined:
  - Adds output port `irq` (1 bit, registered, reset 0).
  - `irq` goes high the cycle after RX becomes non-empty or ovf sets.
  - `irq` drops the cycle after both conditions clear.
  - STATUS[13] mirrors `irq`.
- `PAR_MBOX_IRQ_EN` undefined: no `irq` port, STATUS[13] reads 0, no extra logic.

## Test plan
- Reset, then read all addresses -> RX_DATA=0, STATUS=0x5, addr 2 and 3 read 0, `tx_valid`=0, `rx_ready`=1.
- CPU writes 0x11,0x22,0x33 to addr 2, host holds `tx_ready`=1 -> `tx_data` 0x11,0x22,0x33 on consecutive cycles starting one cycle after the first write, then `tx_valid`=0.
- Host pushes 9 words 0xA0..0xA8 with `tx_ready`=0 on TX and continuous `rx_valid` -> `rx_ready` falls after 8 words, STATUS rx_count=8 and rx_full=1. Repeated RX_DATA read and CTRL=1 pops return 0xA0..0xA7 in order; 0xA8 is accepted after the first pop.
- 9 CPU writes to TX with `tx_ready`=0 -> STATUS tx_count=8, ovf=1, and the ninth word is lost. CTRL=2 -> ovf=0. With `PAR_MBOX_IRQ_EN`, `irq` tracks ovf.
- Full RX and CTRL=1 in the same cycle as `rx_valid` -> pop occurs, push refused, count becomes 7. Next cycle the push is accepted and count returns to 8.
- Both FIFOs partly filled, then CTRL=4 in the same cycle as a host TX pop and a host RX push -> both counts 0, `tx_valid`=0, RX_DATA=0, ovf unchanged.

Source files
------------

// File: rtl/xpar_mbox.sv
// -----------------------------------------------------------------------------
// xpar_mbox
//   Mailbox responder on the picoVersat external parallel bus. The core sees a
//   four-register map (RX_DATA, STATUS, TX_DATA, CTRL). The registers are backed
//   by two small FIFOs:
//     - RX FIFO: filled by the host, drained by the core.
//     - TX FIFO: filled by the core, drained by the host.
//   The host side of both FIFOs is a ready/valid stream.
//
// Build option:
//   PAR_MBOX_IRQ_EN - adds a registered irq output. It is raised while the RX
//                     FIFO holds data or ovf is set, and is mirrored in STATUS[13].
//
// Parameters:
//   DATA_W      width of parallel data and FIFO words
//   PAR_ADDR_W  width of par_addr; only bits [1:0] are decoded
//   FIFO_LOG2   log2 of each FIFO depth
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   par_addr   register address from core (upper bits must be zero)
//   par_we     one-cycle write strobe from core
//   par_out    write data from core
//   par_in     combinational read data to core
//   rx_data    host -> RX FIFO word
//   rx_valid   host word valid
//   rx_ready   RX FIFO accepts (not full, low during reset)
//   tx_data    TX FIFO head word (0 when empty)
//   tx_valid   TX FIFO non-empty
//   tx_ready   host consumes TX head
//   irq        (PAR_MBOX_IRQ_EN only) interrupt request
// -----------------------------------------------------------------------------
module xpar_mbox #(
  parameter int DATA_W     = 32,
  parameter int PAR_ADDR_W = 8,
  parameter int FIFO_LOG2  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PAR_ADDR_W-1:0] par_addr,
  input  logic                  par_we,
  input  logic [DATA_W-1:0]     par_out,
  output logic [DATA_W-1:0]     par_in,
  input  logic [DATA_W-1:0]     rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [DATA_W-1:0]     tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready
`ifdef PAR_MBOX_IRQ_EN
  ,
  output logic                  irq
`endif
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam logic [FIFO_LOG2:0]   DEPTH_C = (FIFO_LOG2 + 1)'(DEPTH);
  localparam logic [FIFO_LOG2-1:0] PTR_ONE = (FIFO_LOG2)'(1);
  localparam logic [FIFO_LOG2:0]   CNT_ONE = (FIFO_LOG2 + 1)'(1);

  // Channel index: 0 = RX FIFO, 1 = TX FIFO
  localparam int CH_RX = 0;
  localparam int CH_TX = 1;

  // ---------------------------------------------------------------------------
  // Register decode
  // ---------------------------------------------------------------------------
  logic       addr_ok;
  logic [1:0] reg_sel;
  logic       tx_wr;
  logic       ctrl_wr;
  logic       flush;

  // Any non-zero upper address bit makes the access fall outside the map.
  assign addr_ok = ((par_addr >> 2) == '0);
  assign reg_sel = par_addr[1:0];
  assign tx_wr   = par_we && addr_ok && (reg_sel == 2'd2);
  assign ctrl_wr = par_we && addr_ok && (reg_sel == 2'd3);
  assign flush   = ctrl_wr && par_out[2];

  // ---------------------------------------------------------------------------
  // FIFO channel wiring
  // ---------------------------------------------------------------------------
  logic [1:0]           empty;
  logic [1:0]           full;
  logic [1:0]           push;
  logic [1:0]           pop;
  logic [DATA_W-1:0]    wr_data [2];
  logic [DATA_W-1:0]    head    [2];
  logic [FIFO_LOG2:0]   count_w [2];

  // Full/empty come from pre-edge state, so a pop never frees room for a push
  // in the same cycle.
  assign rx_ready = !full[CH_RX] && !rst;
  assign push[CH_RX] = rx_valid && rx_ready;
  assign pop[CH_RX]  = ctrl_wr && par_out[0] && !empty[CH_RX];
  assign wr_data[CH_RX] = rx_data;

  assign push[CH_TX] = tx_wr && !full[CH_TX];
  assign pop[CH_TX]  = tx_ready && !empty[CH_TX];
  assign wr_data[CH_TX] = par_out;

  assign tx_valid = !empty[CH_TX];
  assign tx_data  = head[CH_TX];

  // ---------------------------------------------------------------------------
  // Two identical circular-buffer FIFOs
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [DATA_W-1:0]    mem [DEPTH];
      logic [FIFO_LOG2-1:0] wr_ptr_reg, wr_ptr_next;
      logic [FIFO_LOG2-1:0] rd_ptr_reg, rd_ptr_next;
      logic [FIFO_LOG2:0]   count_reg, count_next;

      always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push[gi]) wr_ptr_next = wr_ptr_reg + PTR_ONE;
        if (pop[gi])  rd_ptr_next = rd_ptr_reg + PTR_ONE;
        if (push[gi] && !pop[gi])
          count_next = count_reg + CNT_ONE;
        else if (!push[gi] && pop[gi])
          count_next = count_reg - CNT_ONE;
        // Flush wins over any push or pop in the same cycle.
        if (flush) begin
          wr_ptr_next = '0;
          rd_ptr_next = '0;
          count_next  = '0;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          wr_ptr_reg <= wr_ptr_next;
          rd_ptr_reg <= rd_ptr_next;
          count_reg  <= count_next;
        end
      end

      // Storage is not reset; stale words are unreachable once the
      // pointers and count are cleared.
      always_ff @(posedge clk) begin
        if (push[gi])
          mem[wr_ptr_reg] <= wr_data[gi];
      end

      assign empty[gi]   = (count_reg == '0);
      assign full[gi]    = (count_reg == DEPTH_C);
      assign count_w[gi] = count_reg;
      // Head reads as zero when empty so outputs are clean after reset/flush.
      assign head[gi]    = empty[gi] ? '0 : mem[rd_ptr_reg];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Sticky overflow: set by a TX_DATA write into a full TX FIFO, cleared by
  // CTRL bit1. The two cannot coincide because they are different addresses.
  // ---------------------------------------------------------------------------
  logic ovf_reg, ovf_next;

  always_comb begin
    ovf_next = ovf_reg;
    if (tx_wr && full[CH_TX])
      ovf_next = 1'b1;
    else if (ctrl_wr && par_out[1])
      ovf_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_reg <= 1'b0;
    else     ovf_reg <= ovf_next;
  end

`ifdef PAR_MBOX_IRQ_EN
  // Registered from current state, so irq follows its causes by one cycle.
  logic irq_reg;

  always_ff @(posedge clk) begin
    if (rst) irq_reg <= 1'b0;
    else     irq_reg <= !empty[CH_RX] || ovf_reg;
  end

  assign irq = irq_reg;
`endif

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] status_word;

  always_comb begin
    status_word       = '0;
    status_word[0]    = empty[CH_RX];
    status_word[1]    = full[CH_RX];
    status_word[2]    = empty[CH_TX];
    status_word[3]    = full[CH_TX];
    status_word[7:4]  = 4'(count_w[CH_RX]);
    status_word[11:8] = 4'(count_w[CH_TX]);
    status_word[12]   = ovf_reg;
`ifdef PAR_MBOX_IRQ_EN
    status_word[13]   = irq_reg;
`endif
  end

  always_comb begin
    par_in = '0;
    if (addr_ok) begin
      case (reg_sel)
        2'd0:    par_in = head[CH_RX];
        2'd1:    par_in = status_word;
        default: par_in = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_xpar_mbox.sv
// -----------------------------------------------------------------------------
// tb_xpar_mbox
//   Directed-vector scoreboard bench for xpar_mbox. Stimulus pushes expected
//   values into queues; a monitor on the falling edge pops and compares them,
//   and separately checks every TX stream handshake against an expected-word
//   queue. Works with or without PAR_MBOX_IRQ_EN.
// -----------------------------------------------------------------------------
module tb_xpar_mbox;

  localparam int DW = 32;
  localparam int AW = 8;

`ifdef PAR_MBOX_IRQ_EN
  localparam logic [31:0] IRQB = 32'h0000_2000;
`else
  localparam logic [31:0] IRQB = 32'h0;
`endif

  // Monitor signal selectors
  localparam int SEL_PAR_IN   = 0;
  localparam int SEL_RX_READY = 1;
  localparam int SEL_TX_VALID = 2;
  localparam int SEL_TX_DATA  = 3;
  localparam int SEL_IRQ      = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] par_addr;
  logic          par_we;
  logic [DW-1:0] par_out;
  logic [DW-1:0] par_in;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
`ifdef PAR_MBOX_IRQ_EN
  logic          irq;
`endif

  always #5 clk = ~clk;

  xpar_mbox #(.DATA_W(DW), .PAR_ADDR_W(AW), .FIFO_LOG2(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .par_addr (par_addr),
    .par_we   (par_we),
    .par_out  (par_out),
    .par_in   (par_in),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
`ifdef PAR_MBOX_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  chk_t        chk_q[$];
  logic [31:0] tx_exp_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;

  // ---------------------------------------------------------------------------
  // Monitor: drains the expectation queue each cycle and checks TX handshakes
  // ---------------------------------------------------------------------------
  chk_t        mon_c;
  logic [31:0] mon_act;
  logic [31:0] mon_exp;

  always @(negedge clk) begin
    while (chk_q.size() > 0) begin
      mon_c = chk_q.pop_front();
      case (mon_c.sel)
        SEL_PAR_IN:   mon_act = par_in;
        SEL_RX_READY: mon_act = {31'b0, rx_ready};
        SEL_TX_VALID: mon_act = {31'b0, tx_valid};
        SEL_TX_DATA:  mon_act = tx_data;
`ifdef PAR_MBOX_IRQ_EN
        SEL_IRQ:      mon_act = {31'b0, irq};
`endif
        default:      mon_act = 32'hxxxx_xxxx;
      endcase
      n_cmp++;
      if (mon_act !== mon_c.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", mon_c.name, mon_act, mon_c.exp);
      end else begin
        $display("ok   %s = %h", mon_c.name, mon_act);
      end
    end
    if (tx_valid && tx_ready) begin
      n_cmp++;
      if (tx_exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL tx_stream: got %h expected no word", tx_data);
      end else begin
        mon_exp = tx_exp_q.pop_front();
        if (tx_data !== mon_exp) begin
          n_fail++;
          $display("FAIL tx_stream: got %h expected %h", tx_data, mon_exp);
        end else begin
          $display("ok   tx_stream = %h", tx_data);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_sig(input string name, input int sel, input logic [31:0] exp);
    chk_t c;
    c.name = name;
    c.sel  = sel;
    c.exp  = exp;
    chk_q.push_back(c);
  endtask

  task automatic rd(input logic [AW-1:0] addr, input logic [31:0] exp, input string name);
    par_we   = 1'b0;
    par_addr = addr;
    expect_sig(name, SEL_PAR_IN, exp);
  endtask

  task automatic wr(input logic [AW-1:0] addr, input logic [31:0] data);
    par_we   = 1'b1;
    par_addr = addr;
    par_out  = data;
  endtask

  // Watchdog: the sequence is fixed-length, so this only fires on a stuck sim.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; par_addr = '0; par_we = 1'b0; par_out = '0;
    rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b0;

    // ---------------- Reset and idle register map ----------------
    repeat (2) cyc();
    expect_sig("rx_ready_in_rst", SEL_RX_READY, 32'h0);
    cyc();
    rst = 1'b0;
    rd(8'd0, 32'h0, "rst_rx_data");
    expect_sig("rst_rx_ready", SEL_RX_READY, 32'h1);
    expect_sig("rst_tx_valid", SEL_TX_VALID, 32'h0);
    expect_sig("rst_tx_data",  SEL_TX_DATA,  32'h0);
`ifdef PAR_MBOX_IRQ_EN
    expect_sig("rst_irq", SEL_IRQ, 32'h0);
`endif
    cyc();
    rd(8'd1, 32'h5, "rst_status");   cyc();
    rd(8'd2, 32'h0, "rst_addr2");    cyc();
    rd(8'd3, 32'h0, "rst_addr3");    cyc();
    rd(8'd5, 32'h0, "alias_status"); cyc();

    // ---------------- TX streaming, host always ready ----------------
    tx_ready = 1'b1;
    tx_exp_q.push_back(32'h11);
    tx_exp_q.push_back(32'h22);
    tx_exp_q.push_back(32'h33);
    wr(8'd2, 32'h11); expect_sig("tx2_valid_c0", SEL_TX_VALID, 32'h0); cyc();
    wr(8'd2, 32'h22); expect_sig("tx2_valid_c1", SEL_TX_VALID, 32'h1); cyc();
    wr(8'd2, 32'h33); expect_sig("tx2_valid_c2", SEL_TX_VALID, 32'h1); cyc();
    par_we = 1'b0;    expect_sig("tx2_valid_c3", SEL_TX_VALID, 32'h1); cyc();
    expect_sig("tx2_valid_c4", SEL_TX_VALID, 32'h0); cyc();
    tx_ready = 1'b0;

    // ---------------- RX fill to full, then CPU drain ----------------
    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_data = 32'hA0 + i;
      expect_sig("rx_fill_ready", SEL_RX_READY, 32'h1);
      cyc();
    end
    rx_data = 32'hA8;
    expect_sig("rx_full_ready", SEL_RX_READY, 32'h0);
    rd(8'd1, 32'h86 | IRQB, "rx_full_status");
    cyc();
    for (int i = 0; i < 9; i++) begin
      rd(8'd0, 32'hA0 + i, "rx_head");
      if (i == 0) expect_sig("rx_ready_full", SEL_RX_READY, 32'h0);
      if (i == 1) expect_sig("rx_ready_after_pop", SEL_RX_READY, 32'h1);
      cyc();
      if (i == 1) rx_valid = 1'b0;
      wr(8'd3, 32'h1);
      cyc();
    end
    rd(8'd1, 32'h5 | IRQB, "rx_drained_status"); cyc();
    rd(8'd0, 32'h0, "rx_empty_data");            cyc();

    // ---------------- Full RX: pop and refused push in one cycle ----------------
    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_data = 32'hC0 + i;
      cyc();
    end
    rx_data = 32'hC8;
    wr(8'd3, 32'h1);
    expect_sig("popfull_ready", SEL_RX_READY, 32'h0);
    cyc();
    rd(8'd1, 32'h74 | IRQB, "popfull_cnt7");
    expect_sig("popfull_ready_next", SEL_RX_READY, 32'h1);
    cyc();
    rx_valid = 1'b0;
    rd(8'd1, 32'h86 | IRQB, "popfull_cnt8"); cyc();
    rd(8'd0, 32'hC1, "popfull_head");         cyc();
    wr(8'd3, 32'h4);                          cyc();
    rd(8'd1, 32'h5 | IRQB, "flush_rx_status");
    expect_sig("flush_rx_ready", SEL_RX_READY, 32'h1);
    cyc();
    par_we = 1'b0; cyc();

    // ---------------- TX overflow and ovf clear ----------------
    for (int i = 0; i < 9; i++) begin
      wr(8'd2, 32'hD0 + i);
      cyc();
    end
    rd(8'd1, 32'h1809, "ovf_status");
    expect_sig("ovf_tx_data", SEL_TX_DATA, 32'hD0);
`ifdef PAR_MBOX_IRQ_EN
    expect_sig("ovf_irq_lag", SEL_IRQ, 32'h0);
`endif
    cyc();
    rd(8'd1, 32'h1809 | IRQB, "ovf_status_irq");
`ifdef PAR_MBOX_IRQ_EN
    expect_sig("ovf_irq", SEL_IRQ, 32'h1);
`endif
    cyc();
    wr(8'd3, 32'h2); cyc();
    rd(8'd1, 32'h0809 | IRQB, "ovf_cleared"); cyc();
    rd(8'd1, 32'h0809, "ovf_cleared_irq_low");
`ifdef PAR_MBOX_IRQ_EN
    expect_sig("ovf_irq_drop", SEL_IRQ, 32'h0);
`endif
    cyc();
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) tx_exp_q.push_back(32'hD0 + i);
    repeat (8) cyc();
    tx_ready = 1'b0;
    expect_sig("ovf_ninth_lost", SEL_TX_VALID, 32'h0);
    rd(8'd1, 32'h5, "tx_drained_status");
    cyc();

    // ---------------- Flush against concurrent host push and pop ----------------
    wr(8'd2, 32'hF0); cyc();
    wr(8'd2, 32'hF1); cyc();
    par_we = 1'b0;
    rx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx_data = 32'hE0 + i;
      cyc();
    end
    rx_valid = 1'b0;
    rd(8'd1, 32'h230 | IRQB, "pre_flush_status"); cyc();
    wr(8'd3, 32'h4);
    rx_valid = 1'b1; rx_data = 32'hE3;
    tx_ready = 1'b1;
    tx_exp_q.push_back(32'hF0);
    cyc();
    rx_valid = 1'b0; tx_ready = 1'b0;
    rd(8'd1, 32'h5 | IRQB, "flush_status");
    expect_sig("flush_tx_valid", SEL_TX_VALID, 32'h0);
    expect_sig("flush_tx_data",  SEL_TX_DATA,  32'h0);
    cyc();
    rd(8'd0, 32'h0, "flush_rx_data"); cyc();
    rd(8'd1, 32'h5, "flush_idle");    cyc();

    // ---------------- Reset in the middle of RX traffic ----------------
    rx_valid = 1'b1;
    rx_data = 32'h61; cyc();
    rx_data = 32'h62; cyc();
    rst = 1'b1;
    expect_sig("midrst_ready", SEL_RX_READY, 32'h0);
    cyc();
    rst = 1'b0; rx_valid = 1'b0;
    rd(8'd1, 32'h5, "midrst_status"); cyc();
    rd(8'd0, 32'h0, "midrst_rx_data"); cyc();
    cyc();

    // Every expected TX word must have been seen.
    n_cmp++;
    if (tx_exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL tx_leftover: got %0d words pending expected 0", tx_exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
